// File: rtl/bht_access_ctrl.sv
// Port sequencer for a single-port BHT of saturating counters: post-reset table sweep,
// lookup/update arbitration, and read-modify-write from an update queue. Macro: BHT_MISS_STATS_EN.
module bht_access_ctrl #(
    parameter int IDX_W  = 3,
    parameter int CTR_W  = 2,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lk_valid,
    input  logic [IDX_W-1:0] lk_id,
    output logic             lk_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_id,
    input  logic             upd_outcome,
    output logic             upd_ready,
    output logic             busy_init,
    output logic [IDX_W-1:0] bht_addr,
    output logic             bht_we,
    output logic [CTR_W-1:0] bht_wdata,
    input  logic [CTR_W-1:0] bht_rdata,
    output logic [15:0]      miss_count
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    typedef enum logic [1:0] {INIT, IDLE, UPD_WR} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] sweep_q;
    logic [IDX_W-1:0] hold_id_q;
    logic             hold_out_q;
    logic             pred_valid_q;

    logic [IDX_W-1:0] q_id_q  [QDEPTH];
    logic             q_out_q [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             full, nonempty, upd_sel, push, pop, lk_acc;
    logic [CTR_W-1:0] new_ctr;

    assign full     = (cnt_q == CNT_W'(QDEPTH));
    assign nonempty = (cnt_q != '0);
    assign upd_sel  = full || (nonempty && !lk_valid);
    assign push     = upd_valid && upd_ready;
    assign cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        if (hold_out_q) new_ctr = (bht_rdata == CTR_MAX) ? bht_rdata : bht_rdata + 1'b1;
        else            new_ctr = (bht_rdata == '0)      ? bht_rdata : bht_rdata - 1'b1;
    end

    // Port outputs are decoded from state so a lookup's read issues in its accept cycle;
    // reset gates them so nothing is written while reset is held.
    always_comb begin
        lk_ready  = 1'b0;
        upd_ready = 1'b0;
        bht_addr  = '0;
        bht_we    = 1'b0;
        bht_wdata = '0;
        pop       = 1'b0;
        lk_acc    = 1'b0;
        if (!reset) begin
            case (state_q)
                INIT: begin
                    bht_we   = 1'b1;
                    bht_addr = sweep_q;
                end
                IDLE: begin
                    upd_ready = !full;
                    lk_ready  = !upd_sel;
                    if (upd_sel) begin
                        pop      = 1'b1;
                        bht_addr = q_id_q[rd_ptr_q];
                    end else if (lk_valid) begin
                        lk_acc   = 1'b1;
                        bht_addr = lk_id;
                    end
                end
                UPD_WR: begin
                    upd_ready = !full;
                    bht_we    = 1'b1;
                    bht_addr  = hold_id_q;
                    bht_wdata = new_ctr;
                end
                default: ;
            endcase
        end
    end

    assign busy_init  = reset || (state_q == INIT);
    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_valid_q & bht_rdata[CTR_W-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= INIT;
            sweep_q      <= '0;
            hold_id_q    <= '0;
            hold_out_q   <= 1'b0;
            pred_valid_q <= 1'b0;
        end else begin
            pred_valid_q <= lk_acc;
            case (state_q)
                INIT: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == '1) state_q <= IDLE;
                end
                IDLE: begin
                    if (pop) begin
                        hold_id_q  <= q_id_q[rd_ptr_q];
                        hold_out_q <= q_out_q[rd_ptr_q];
                        state_q    <= UPD_WR;
                    end
                end
                UPD_WR:  state_q <= IDLE;
                default: state_q <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_id_q[wr_ptr_q]  <= upd_id;
            q_out_q[wr_ptr_q] <= upd_outcome;
        end
    end

`ifdef BHT_MISS_STATS_EN
    logic        miss;
    logic [15:0] miss_cnt_q;
    assign miss = (bht_rdata[CTR_W-1] != hold_out_q);
    always_ff @(posedge clk) begin
        if (reset)
            miss_cnt_q <= '0;
        else if (state_q == UPD_WR && miss && miss_cnt_q != 16'hFFFF)
            miss_cnt_q <= miss_cnt_q + 16'd1;
    end
    assign miss_count = miss_cnt_q;
`else
    assign miss_count = '0;
`endif
endmodule
